// File: rtl/s3g_rx.sv
// s3g_rx: S3G packet receiver (0xD5 hunt, length, up to 16 payload bytes, Maxim CRC-8 check).
// Optional inter-byte timeout enabled by defining S3G_RX_TIMEOUT_EN.
module s3g_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       rx_packet_done,
  output logic       rx_packet_error,
  output logic       rx_buffer_valid,
  output logic [7:0] rx_payload_len,
  output logic [7:0] rx_buf0,
  output logic [7:0] rx_buf1,
  output logic [7:0] rx_buf2,
  output logic [7:0] rx_buf3,
  output logic [7:0] rx_buf4,
  output logic [7:0] rx_buf5,
  output logic [7:0] rx_buf6,
  output logic [7:0] rx_buf7,
  output logic [7:0] rx_buf8,
  output logic [7:0] rx_buf9,
  output logic [7:0] rx_buf10,
  output logic [7:0] rx_buf11,
  output logic [7:0] rx_buf12,
  output logic [7:0] rx_buf13,
  output logic [7:0] rx_buf14,
  output logic [7:0] rx_buf15,
  output logic [7:0] rx_error_count
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CRC} state_t;

  state_t     state, state_nx;
  logic [7:0] buf_q [16];
  logic [3:0] idx;
  logic [7:0] crc;
  logic       timeout;
  logic       start, len_wr, pay_wr, done_d, err_d;

  // Maxim CRC-8: reflected poly 0x8C, LSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

`ifdef S3G_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            to_cnt <= '0;
    else if (uart_valid || state == S_IDLE) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != S_IDLE) && !uart_valid && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (uart_valid && uart_data == 8'hD5) state_nx = S_LEN;
      S_LEN: begin
        if (timeout) state_nx = S_IDLE;
        else if (uart_valid) begin
          if (uart_data > 8'd16)       state_nx = S_IDLE;
          else if (uart_data == 8'd0)  state_nx = S_CRC;
          else                         state_nx = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (timeout) state_nx = S_IDLE;
        else if (uart_valid && {4'd0, idx} == rx_payload_len - 8'd1) state_nx = S_CRC;
      end
      S_CRC:     if (timeout || uart_valid) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start  = uart_valid && state == S_IDLE && uart_data == 8'hD5;
    len_wr = uart_valid && state == S_LEN;
    pay_wr = uart_valid && state == S_PAYLOAD;
    done_d = uart_valid && state == S_CRC && uart_data == crc;
    err_d  = timeout
          || (len_wr && uart_data > 8'd16)
          || (uart_valid && state == S_CRC && uart_data != crc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_packet_done  <= 1'b0;
      rx_packet_error <= 1'b0;
      rx_buffer_valid <= 1'b0;
      rx_payload_len  <= 8'd0;
      rx_error_count  <= 8'd0;
      idx             <= 4'd0;
      crc             <= 8'd0;
      for (int i = 0; i < 16; i++) buf_q[i] <= 8'd0;
    end else begin
      rx_packet_done  <= done_d;
      rx_packet_error <= err_d;
      if (err_d && rx_error_count != 8'hFF) rx_error_count <= rx_error_count + 8'd1;
      if (start) begin
        rx_buffer_valid <= 1'b0;
        crc             <= 8'd0;
        for (int i = 0; i < 16; i++) buf_q[i] <= 8'd0;
      end
      if (done_d) rx_buffer_valid <= 1'b1;
      if (len_wr) begin
        rx_payload_len <= uart_data;
        idx            <= 4'd0;
      end
      if (pay_wr) begin
        buf_q[idx] <= uart_data;
        crc        <= crc8_byte(crc, uart_data);
        idx        <= idx + 4'd1;
      end
    end
  end

  assign rx_buf0  = buf_q[0];
  assign rx_buf1  = buf_q[1];
  assign rx_buf2  = buf_q[2];
  assign rx_buf3  = buf_q[3];
  assign rx_buf4  = buf_q[4];
  assign rx_buf5  = buf_q[5];
  assign rx_buf6  = buf_q[6];
  assign rx_buf7  = buf_q[7];
  assign rx_buf8  = buf_q[8];
  assign rx_buf9  = buf_q[9];
  assign rx_buf10 = buf_q[10];
  assign rx_buf11 = buf_q[11];
  assign rx_buf12 = buf_q[12];
  assign rx_buf13 = buf_q[13];
  assign rx_buf14 = buf_q[14];
  assign rx_buf15 = buf_q[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Scoreboard bench for s3g_rx: driver queues expected pulses, negedge monitor checks them.
module tb_s3g_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] uart_data = 8'd0;
  logic       uart_valid = 1'b0;
  logic       rx_packet_done, rx_packet_error, rx_buffer_valid;
  logic [7:0] rx_payload_len, rx_error_count;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15;
  logic [127:0] bufs;

  always #5 clk = ~clk;

  s3g_rx #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_valid(uart_valid),
    .rx_packet_done(rx_packet_done), .rx_packet_error(rx_packet_error),
    .rx_buffer_valid(rx_buffer_valid), .rx_payload_len(rx_payload_len),
    .rx_buf0(b0), .rx_buf1(b1), .rx_buf2(b2), .rx_buf3(b3),
    .rx_buf4(b4), .rx_buf5(b5), .rx_buf6(b6), .rx_buf7(b7),
    .rx_buf8(b8), .rx_buf9(b9), .rx_buf10(b10), .rx_buf11(b11),
    .rx_buf12(b12), .rx_buf13(b13), .rx_buf14(b14), .rx_buf15(b15),
    .rx_error_count(rx_error_count)
  );

  assign bufs = {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};

  typedef struct packed {
    logic         is_done;
    logic [7:0]   len;
    logic [127:0] bufs;
    logic         bval;
    logic [7:0]   ecnt;
    logic [31:0]  due;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;
  int   ncyc = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  task automatic send(input logic [7:0] b);
    uart_data  = b;
    uart_valid = 1'b1;
    @(posedge clk);
    #1;
    uart_valid = 1'b0;
  endtask

  task automatic expect_pulse(input logic d, input logic [7:0] len, input logic [127:0] bv,
                              input logic bval, input int lat);
    exp_t e;
    if (!d) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    e.is_done = d;
    e.len     = len;
    e.bufs    = bv;
    e.bval    = bval;
    e.ecnt    = 8'(exp_err);
    e.due     = 32'(ncyc + lat);
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expectation, on the expected cycle
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst && (rx_packet_done || rx_packet_error)) begin
      chk("done_and_error_exclusive", {127'd0, rx_packet_done & rx_packet_error}, 128'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {126'd0, rx_packet_done, rx_packet_error}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", 128'(ncyc), 128'(e.due));
        chk("pulse_kind", {126'd0, rx_packet_done, rx_packet_error}, {126'd0, e.is_done, ~e.is_done});
        chk("payload_len", 128'(rx_payload_len), 128'(e.len));
        chk("buffer", bufs, e.bufs);
        chk("buffer_valid", 128'(rx_buffer_valid), 128'(e.bval));
        chk("error_count", 128'(rx_error_count), 128'(e.ecnt));
      end
    end else if (q.size() != 0 && int'(q[0].due) <= ncyc) begin
      e = q.pop_front();
      chk("missing_pulse", 128'd0, {127'd0, 1'b1});
    end
  end

  initial begin
    logic [7:0]   c;
    logic [127:0] bv;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 128'(rx_packet_done), 128'd0);
    chk("reset_error", 128'(rx_packet_error), 128'd0);
    chk("reset_bval", 128'(rx_buffer_valid), 128'd0);
    chk("reset_len", 128'(rx_payload_len), 128'd0);
    chk("reset_bufs", bufs, 128'd0);
    chk("reset_ecnt", 128'(rx_error_count), 128'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // noise then good one-byte packet
    send(8'h00); send(8'hFF); send(8'hD5); send(8'h01); send(8'h01); send(8'h5E);
    expect_pulse(1'b1, 8'd1, 128'h01, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;

    // bad CRC: partial data remains, buffer not valid
    send(8'hD5); send(8'h01); send(8'h01); send(8'h00);
    expect_pulse(1'b0, 8'd1, 128'h01, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;

    // zero-length packet
    send(8'hD5); send(8'h00); send(8'h00);
    expect_pulse(1'b1, 8'd0, 128'd0, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bval_held", 128'(rx_buffer_valid), 128'd1);
    send(8'hD5);
    chk("bval_cleared_by_start", 128'(rx_buffer_valid), 128'd0);

    // oversize length (already in length state after the lone start byte)
    send(8'h11);
    expect_pulse(1'b0, 8'h11, 128'd0, 1'b0, 1);
    send(8'hD5); send(8'h01); send(8'h00); send(8'h00);
    expect_pulse(1'b1, 8'd1, 128'd0, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;

    // full 16-byte packet, back-to-back
    c = 8'd0;
    bv = '0;
    send(8'hD5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i + 1));
      c = crc_upd(c, 8'(i + 1));
      bv[8*i +: 8] = 8'(i + 1);
    end
    send(c);
    expect_pulse(1'b1, 8'd16, bv, 1'b1, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("buffer_stable_after_done", bufs, bv);

    // 0xD5 treated as data inside a packet
    c = crc_upd(crc_upd(8'd0, 8'hD5), 8'hD5);
    send(8'hD5); send(8'h02); send(8'hD5); send(8'hD5); send(c);
    expect_pulse(1'b1, 8'd2, 128'hD5D5, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;

    // stalled packet
    send(8'hD5); send(8'h02); send(8'h01);
`ifdef S3G_RX_TIMEOUT_EN
    expect_pulse(1'b0, 8'd2, 128'h01, 1'b0, 51);
    repeat (55) @(posedge clk);
    #1;
    send(8'hD5); send(8'h01); send(8'h01); send(8'h5E);
    expect_pulse(1'b1, 8'd1, 128'h01, 1'b1, 1);
`else
    repeat (60) @(posedge clk);
    #1;
    chk("no_timeout_ecnt", 128'(rx_error_count), 128'(exp_err));
    c = crc_upd(crc_upd(8'd0, 8'h01), 8'h02);
    send(8'h02); send(c);
    expect_pulse(1'b1, 8'd2, 128'h0201, 1'b1, 1);
`endif
    repeat (2) @(posedge clk);
    #1;

    // error counter saturation
    for (int i = 0; i < 258; i++) begin
      send(8'hD5); send(8'hFF);
      expect_pulse(1'b0, 8'hFF, 128'd0, 1'b0, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("ecnt_saturated", 128'(rx_error_count), 128'd255);

    // reset mid-packet clears everything immediately
    send(8'hD5); send(8'h03); send(8'h01);
    rst = 1'b0;
    #1;
    chk("midreset_len", 128'(rx_payload_len), 128'd0);
    chk("midreset_bufs", bufs, 128'd0);
    chk("midreset_ecnt", 128'(rx_error_count), 128'd0);
    exp_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(8'hD5); send(8'h01); send(8'h01); send(8'h5E);
    expect_pulse(1'b1, 8'd1, 128'h01, 1'b1, 1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
